// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL configuration controller: applies a mode table entry under PLL reset,
// waits for a filtered lock, retries on timeout and recovers from lock loss.
module pll_dyn_ctrl #(
  parameter int NUM_MODES = 4,
  parameter logic [18*NUM_MODES-1:0] MODE_TABLE = {
    6'd1, 6'd32, 6'd8,
    6'd1, 6'd24, 6'd4,
    6'd1, 6'd16, 6'd4,
    6'd1, 6'd8,  6'd2
  },
  parameter int INIT_MODE    = 0,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [MW-1:0] req_mode,
  output logic          req_ready,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic [MW-1:0] cur_mode,
  output logic          clk_ok,
  output logic          cfg_err,
  output logic          lock_lost
);

  localparam int RCW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
  localparam int SCW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
  localparam int TCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int RTW = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RCW-1:0] RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_LAST  = SCW'(LOCK_STABLE - 1);
  localparam logic [TCW-1:0] TO_LAST    = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [RTW-1:0] RETRY_MAX  = RTW'(MAX_RETRY);
  localparam logic [MW-1:0]  INIT_M     = MW'(INIT_MODE);

  typedef enum logic [1:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_LOCKED,
    S_ERROR
  } state_t;

  function automatic logic [17:0] mode_cfg(input logic [MW-1:0] m);
    return MODE_TABLE[18*int'(m) +: 18];
  endfunction

  state_t         state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0] stab_cnt_q, stab_cnt_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic [RTW-1:0] retry_q, retry_d;
  logic [MW-1:0]  mode_q, mode_d;
  logic [17:0]    sel_q, sel_d;
  logic [1:0]     sync_q;
  logic           pll_reset_q, pll_reset_d;
  logic           clk_ok_q, clk_ok_d;
  logic           cfg_err_q, cfg_err_d;
  logic           lock_lost_q, lock_lost_d;
  logic           req_ready_q, req_ready_d;
  logic           lock_s;
  logic           accept;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stab_cnt_d  = stab_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_d     = retry_q;
    mode_d      = mode_q;
    cfg_err_d   = cfg_err_q;
    lock_lost_d = 1'b0;
    accept      = req_valid && req_ready_q && (int'(req_mode) < NUM_MODES);

    unique case (state_q)
      S_PLL_RST: begin
        to_cnt_d   = '0;
        stab_cnt_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = S_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        stab_cnt_d = lock_s ? stab_cnt_q + 1'b1 : '0;
        to_cnt_d   = to_cnt_q + 1'b1;
        // A lock reaching the stability count in the timeout cycle still wins.
        if (lock_s && (stab_cnt_q == STAB_LAST)) begin
          stab_cnt_d = '0;
          to_cnt_d   = '0;
          retry_d    = '0;
          state_d    = S_LOCKED;
        end else if (to_cnt_q == TO_LAST) begin
          stab_cnt_d = '0;
          to_cnt_d   = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_PLL_RST;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      S_LOCKED: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          retry_d     = '0;
          rst_cnt_d   = '0;
          state_d     = S_PLL_RST;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    if (accept) begin
      mode_d     = req_mode;
      retry_d    = '0;
      cfg_err_d  = 1'b0;
      rst_cnt_d  = '0;
      stab_cnt_d = '0;
      to_cnt_d   = '0;
      state_d    = S_PLL_RST;
    end

    // Selects only ever change on entry to reset, so they are stable while the PLL runs.
    sel_d       = (state_d == S_PLL_RST) ? mode_cfg(mode_d) : sel_q;
    pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_ERROR);
    clk_ok_d    = (state_d == S_LOCKED);
    req_ready_d = (state_d == S_LOCKED) || (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      rst_cnt_q   <= '0;
      stab_cnt_q  <= '0;
      to_cnt_q    <= '0;
      retry_q     <= '0;
      mode_q      <= INIT_M;
      sel_q       <= mode_cfg(INIT_M);
      sync_q      <= '0;
      pll_reset_q <= 1'b1;
      clk_ok_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stab_cnt_q  <= stab_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      sync_q      <= {sync_q[0], pll_lock};
      pll_reset_q <= pll_reset_d;
      clk_ok_q    <= clk_ok_d;
      cfg_err_q   <= cfg_err_d;
      lock_lost_q <= lock_lost_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pll_reset = pll_reset_q;
  assign idsel     = sel_q[17:12];
  assign fbdsel    = sel_q[11:6];
  assign odsel     = sel_q[5:0];
  assign cur_mode  = mode_q;
  assign clk_ok    = clk_ok_q;
  assign cfg_err   = cfg_err_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: directed scenarios with literal expectations, then random
// traffic, all outputs compared each cycle against a phase/timer model of the controller.
`timescale 1ns/1ps
module tb_pll_dyn_ctrl;
  localparam int NM = 5;
  localparam int RC = 16;
  localparam int LS = 32;
  localparam int LT = 300;
  localparam int MR = 3;
  localparam logic [18*NM-1:0] TBL = {
    6'd5, 6'd50, 6'd6,
    6'd4, 6'd40, 6'd5,
    6'd3, 6'd30, 6'd4,
    6'd2, 6'd20, 6'd3,
    6'd1, 6'd10, 6'd2
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_mode = '0;
  logic       pll_lock = 1'b0;
  logic       req_ready, pll_reset, clk_ok, cfg_err, lock_lost;
  logic [5:0] idsel, fbdsel, odsel;
  logic [2:0] cur_mode;

  always #5 clk = ~clk;

  pll_dyn_ctrl #(
    .NUM_MODES(NM), .MODE_TABLE(TBL), .INIT_MODE(0), .RST_CYCLES(RC),
    .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel), .cur_mode(cur_mode),
    .clk_ok(clk_ok), .cfg_err(cfg_err), .lock_lost(lock_lost)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      if (n_err >= 40) finish_run();
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      if (n_err >= 40) finish_run();
    end
  endtask

  // Reference model: phase letter, time spent in phase, current lock run, attempt number.
  int  exp_id [NM] = '{1, 2, 3, 4, 5};
  int  exp_fb [NM] = '{10, 20, 30, 40, 50};
  int  exp_od [NM] = '{2, 3, 4, 5, 6};
  byte ph = "R";
  int  el = 0, run = 0, att = 1, m_mode = 0;
  bit  m_cfg = 0, m_lost = 0, lk1 = 0, lk2 = 0, started = 0;

  always @(posedge clk) begin : model
    bit ls, rdy, acc;
    ls  = lk2;
    rdy = (ph == "L") || (ph == "E");
    acc = rdy && req_valid && (int'(req_mode) < NM);
    m_lost = 0;
    if (rst) begin
      ph = "R"; el = 0; run = 0; att = 1; m_mode = 0; m_cfg = 0;
      lk1 = 0; lk2 = 0; started = 1;
    end else begin
      case (ph)
        "R": begin
          el++;
          if (el == RC) begin ph = "W"; el = 0; run = 0; end
        end
        "W": begin
          el++;
          run = ls ? run + 1 : 0;
          if (run == LS) begin
            ph = "L"; att = 1;
          end else if (el == LT) begin
            el = 0;
            if (att <= MR) begin att++; ph = "R"; end
            else begin ph = "E"; m_cfg = 1; end
          end
        end
        "L": if (!ls) begin m_lost = 1; ph = "R"; el = 0; att = 1; end
        default: ;
      endcase
      if (acc) begin
        m_mode = int'(req_mode); ph = "R"; el = 0; att = 1; m_cfg = 0;
      end
      lk2 = lk1;
      lk1 = pll_lock;
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] ctl_e;
    if (started) begin
      ctl_e = {(ph == "R") || (ph == "E"), ph == "L", (ph == "L") || (ph == "E"), m_cfg, m_lost};
      check("ctrl", 32'({pll_reset, clk_ok, req_ready, cfg_err, lock_lost}), 32'(ctl_e));
      check("mode", 32'(cur_mode), 32'(m_mode));
      check("sel", 32'({idsel, fbdsel, odsel}),
            32'({6'(exp_id[m_mode]), 6'(exp_fb[m_mode]), 6'(exp_od[m_mode])}));
    end
  end

  initial begin : stim
    int got, hi, lost, hits, rises;
    bit prev, low_seen;

    repeat (4) @(negedge clk);
    check("rst_pll_reset", 32'(pll_reset), 1);
    check("rst_clk_ok", 32'(clk_ok), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_cur_mode", 32'(cur_mode), 0);
    check("rst_sel", 32'({idsel, fbdsel, odsel}), 32'({6'd1, 6'd10, 6'd2}));

    // Power-up: lock rises 100 cycles after pll_reset falls.
    rst = 1'b0;
    hi = pll_reset ? 1 : 0;
    got = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (pll_reset) hi++;
      if (k == 116) pll_lock = 1'b1;
      if (clk_ok) begin got = k; break; end
    end
    check_rng("powerup_clk_ok_cycle", got, 149, 151);
    check("powerup_reset_len", 32'(hi), 16);
    check("powerup_mode", 32'(cur_mode), 0);

    // Mode switch to 2.
    req_valid = 1'b1; req_mode = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("switch_ready_low", 32'(req_ready), 0);
    check("switch_reset_high", 32'(pll_reset), 1);
    check("switch_sel", 32'({idsel, fbdsel, odsel}), 32'({6'd3, 6'd30, 6'd4}));
    for (int k = 0; k < 200 && !clk_ok; k++) @(negedge clk);
    check("switch_relock", 32'(clk_ok), 1);
    check("switch_cur_mode", 32'(cur_mode), 2);

    // Out-of-range mode is ignored.
    req_valid = 1'b1; req_mode = 3'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("invalid_ready", 32'(req_ready), 1);
    check("invalid_reset", 32'(pll_reset), 0);
    check("invalid_mode", 32'(cur_mode), 2);

    // Lock glitch of three cycles.
    pll_lock = 1'b0; lost = 0; hi = 0; low_seen = 0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 3) pll_lock = 1'b1;
      if (lock_lost) lost++;
      if (pll_reset) hi++;
      if (!clk_ok) low_seen = 1;
    end
    check("glitch_lost_pulses", 32'(lost), 1);
    check("glitch_reset_len", 32'(hi), 16);
    check("glitch_clk_ok_dropped", 32'(low_seen), 1);
    check("glitch_relock", 32'(clk_ok), 1);

    // Timeout and retries with lock held low.
    pll_lock = 1'b0; req_valid = 1'b1; req_mode = 3'd1;
    prev = pll_reset; rises = 0; got = 0;
    for (int k = 1; k <= 1400; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (pll_reset && !prev) rises++;
      prev = pll_reset;
      if (cfg_err) begin got = k; break; end
    end
    check("timeout_err_cycle", 32'(got), 1265);
    check("timeout_reset_rises", 32'(rises), 5);
    check("timeout_reset_held", 32'(pll_reset), 1);
    req_valid = 1'b1; req_mode = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    check("err_cleared", 32'(cfg_err), 0);
    check("err_new_mode", 32'(cur_mode), 3);

    // Lock toggling faster than the stability window never qualifies.
    hits = 0;
    for (int k = 1; k <= 400; k++) begin
      if (k % 20 == 0) pll_lock = ~pll_lock;
      @(negedge clk);
      if (clk_ok) hits++;
    end
    check("filter_no_clk_ok", 32'(hits), 0);

    pll_lock = 1'b1;
    for (int k = 0; k < 800 && !clk_ok; k++) @(negedge clk);
    check("filter_relock", 32'(clk_ok), 1);

    // Same-mode request still reconfigures; then reset mid-WAIT_LOCK.
    req_valid = 1'b1; req_mode = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    check("same_mode_reset", 32'(pll_reset), 1);
    check("same_mode_clk_ok", 32'(clk_ok), 0);
    repeat (25) @(negedge clk);
    check("in_wait_lock", 32'(pll_reset), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_mode", 32'(cur_mode), 0);
    check("midrst_reset", 32'(pll_reset), 1);
    check("midrst_sel", 32'({idsel, fbdsel, odsel}), 32'({6'd1, 6'd10, 6'd2}));

    // Random traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      rst       = ($urandom_range(0, 999) == 0);
      req_valid = ($urandom_range(0, 19) == 0);
      req_mode  = 3'($urandom_range(0, 7));
      if (pll_lock) pll_lock = ($urandom_range(0, 199) != 0);
      else          pll_lock = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    finish_run();
  end
endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 Parameter NUM_MODES, default 4: number of selectable PLL configurations (1..8).
REQ-002 Parameter MODE_TABLE, default 4x18 bits: per mode {IDSEL[17:12], FBDSEL[11:6], ODSEL[5:0]}; mode m at bits [18m+17:18m]; codes emitted unchanged.
REQ-003 Parameter INIT_MODE, default 0: mode applied after reset.
REQ-004 Parameter RST_CYCLES, default 16: pll_reset high time per attempt, in clk cycles.
REQ-005 Parameter LOCK_STABLE, default 256: consecutive synced-lock-high cycles needed before clk_ok.
REQ-006 Parameter LOCK_TIMEOUT, default 65536: max cycles waiting for lock per attempt.
REQ-007 Parameter MAX_RETRY, default 3: extra attempts after a first timeout.
REQ-008 clk  in  1  free-running reference clock, not derived from the controlled PLL.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 req_valid  in  1  mode-change request.
REQ-011 req_mode  in  clog2(NUM_MODES) (min 1)  requested mode index.
REQ-012 req_ready  out  1  controller accepts a request this cycle.
REQ-013 pll_lock  in  1  PLL LOCK, asynchronous to clk.
REQ-014 pll_reset  out  1  drives PLL RESET.
REQ-015 idsel, fbdsel, odsel  out  6 each  drive PLL dynamic IDSEL/FBDSEL/ODSEL.
REQ-016 cur_mode  out  clog2(NUM_MODES)  mode currently applied.
REQ-017 clk_ok  out  1  PLL output is stable and usable.
REQ-018 cfg_err  out  1  configuration failed after all retries.
REQ-019 lock_lost  out  1  one-cycle pulse on unexpected lock loss.

Function
REQ-020 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s.
REQ-021 FSM states: PLL_RST, WAIT_LOCK, LOCKED, ERROR.
REQ-022 PLL_RST: pll_reset=1, sel outputs = MODE_TABLE[cur_mode]; after RST_CYCLES cycles -> WAIT_LOCK; timeout counter cleared.
REQ-023 WAIT_LOCK: pll_reset=0; stable counter increments while lock_s=1, clears to 0 when lock_s=0; reaching LOCK_STABLE -> LOCKED.
REQ-024 WAIT_LOCK: when timeout counter reaches LOCK_TIMEOUT without reaching LOCKED: if retries used < MAX_RETRY -> PLL_RST with retry count+1, else -> ERROR.
REQ-025 LOCKED: clk_ok=1, req_ready=1, retry count=0.
REQ-026 ERROR: cfg_err=1, clk_ok=0, pll_reset=1 held, req_ready=1.
REQ-027 Request accepted when req_valid & req_ready; cur_mode<=req_mode, retry count cleared, cfg_err cleared, next state PLL_RST; sel outputs update in the same cycle pll_reset rises, never while pll_reset=0.
REQ-028 req_mode >= NUM_MODES SHALL be accepted and ignored: no state change, cur_mode unchanged.
REQ-029 req_ready=0 in PLL_RST and WAIT_LOCK; requests there are dropped, not queued.
REQ-030 Lock loss in LOCKED (lock_s=0): clk_ok falls the next cycle, lock_lost pulses one cycle, -> PLL_RST with same cur_mode, retry count cleared.
REQ-031 Request to current mode while LOCKED SHALL still perform the full reconfiguration sequence.
REQ-032 Counters sized to their parameter by clog2; no wrap-around permitted.
REQ-033 clk_ok is registered, high only in LOCKED.

Reset
REQ-034 During rst: state=PLL_RST with counters cleared, pll_reset=1, cur_mode=INIT_MODE, sel outputs=MODE_TABLE[INIT_MODE], clk_ok=0, cfg_err=0, lock_lost=0, req_ready=0, synchronizer flops=0, retry count=0.
REQ-035 rst asserted mid-sequence SHALL abandon it and restart from INIT_MODE on the following cycle.

Verification
REQ-036 Power-up: rst 4 cycles, pll_lock high 100 cycles after release -> pll_reset high 16 cycles, clk_ok at release+16+100+2+256 (+/-1), cur_mode=0.
REQ-037 Mode switch: LOCKED, req_valid with req_mode=2 -> req_ready falls next cycle, sel = MODE_TABLE[2] while pll_reset=1, clk_ok returns after relock, cur_mode=2.
REQ-038 Timeout/retry: pll_lock held 0 -> exactly 4 pll_reset pulses spaced 16+65536 cycles, then cfg_err=1, pll_reset=1; new request clears cfg_err.
REQ-039 Lock glitch: LOCKED, pll_lock low 3 cycles -> lock_lost single pulse, clk_ok=0, pll_reset high 16 cycles, relock.
REQ-040 Stability filter: in WAIT_LOCK, lock toggling every 100 cycles -> clk_ok never asserts; invalid req_mode=5 with NUM_MODES=4 -> ignored.
REQ-041 Reset mid-WAIT_LOCK after a switch to mode 3 -> cur_mode=0, pll_reset=1 next cycle.
